// File: rtl/multichannel_noise_gate.sv
// Time-multiplexed multichannel noise gate: per-channel peak envelope,
// five-state gate FSM with hysteresis and hold, and a linear gain ramp.
module multichannel_noise_gate #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned HOLD_W    = 16,
  parameter int unsigned ENV_SHIFT = 8,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] thresh_open,
  input  logic [DATA_W-1:0] thresh_close,
  input  logic [HOLD_W-1:0] hold_samples,
  input  logic [GAIN_W-1:0] attack_step,
  input  logic [GAIN_W-1:0] release_step,
  input  logic [GAIN_W-1:0] floor_gain,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0] gate_open
);

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } gate_st_e;

  localparam int unsigned CHX_W  = CH_W + 1;
  localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] UNITY   = {1'b1, {(GAIN_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  gate_st_e          st_q   [NUM_CH];
  logic [DATA_W-1:0] env_q  [NUM_CH];
  logic [GAIN_W-1:0] gain_q [NUM_CH];
  logic [HOLD_W-1:0] hold_q [NUM_CH];
  logic [NUM_CH-1:0] gate_open_q;

  logic              ch_ok, wr_en;
  logic [CH_W-1:0]   idx;
  gate_st_e          cur_st, st_d;
  logic [DATA_W-1:0] cur_env, env_d, abs_v;
  logic [GAIN_W-1:0] cur_gain, gain_d, floor_eff;
  logic [HOLD_W-1:0] cur_hold, hold_d;
  logic [GAIN_W:0]   gain_up, gain_dn;

  logic              s1_valid_q;
  logic [CH_W-1:0]   s1_ch_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [GAIN_W-1:0] s1_gain_q;

  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [DATA_W-1:0] out_data_q;

  logic signed [PROD_W-1:0] prod_a_c, prod_b_c, prod_c;
  logic                     prod_unused_c;

  // Stage 1: read the addressed channel, update envelope, FSM and gain
  always_comb begin
    ch_ok     = in_valid && (CHX_W'(in_ch) < CHX_W'(NUM_CH));
    wr_en     = ch_ok && enable;
    idx       = ch_ok ? in_ch : '0;
    cur_st    = st_q[idx];
    cur_env   = env_q[idx];
    cur_gain  = gain_q[idx];
    cur_hold  = hold_q[idx];
    floor_eff = (floor_gain > UNITY) ? UNITY : floor_gain;

    if (!in_data[DATA_W-1])        abs_v = in_data;
    else if (in_data == ~MAX_POS)  abs_v = MAX_POS;
    else                           abs_v = ~in_data + DATA_W'(1);

    env_d  = (abs_v > cur_env) ? abs_v : cur_env - (cur_env >> ENV_SHIFT);
    st_d   = cur_st;
    hold_d = cur_hold;

    case (cur_st)
      ST_CLOSED:  if (env_d >= thresh_open) st_d = ST_ATTACK;
      ST_ATTACK: begin
        if (env_d < thresh_close)  st_d = ST_RELEASE;
        else if (cur_gain == UNITY) st_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (env_d < thresh_close) begin
          if (hold_samples == '0) st_d = ST_RELEASE;
          else begin
            st_d   = ST_HOLD;
            hold_d = hold_samples;
          end
        end
      end
      ST_HOLD: begin
        if (env_d >= thresh_open)         st_d = ST_OPEN;
        else if (cur_hold <= HOLD_W'(1))  st_d = ST_RELEASE;
        else                              hold_d = cur_hold - HOLD_W'(1);
      end
      ST_RELEASE: begin
        if (env_d >= thresh_open)     st_d = ST_ATTACK;
        else if (cur_gain == floor_eff) st_d = ST_CLOSED;
      end
      default: st_d = ST_CLOSED;
    endcase

    gain_up = {1'b0, cur_gain} + {1'b0, attack_step};
    gain_dn = {1'b0, cur_gain} - {1'b0, release_step};
    case (st_d)
      ST_ATTACK:  gain_d = (gain_up > {1'b0, UNITY}) ? UNITY : gain_up[GAIN_W-1:0];
      ST_OPEN,
      ST_HOLD:    gain_d = UNITY;
      ST_RELEASE: gain_d = (gain_dn[GAIN_W] || (gain_dn[GAIN_W-1:0] < floor_eff))
                           ? floor_eff : gain_dn[GAIN_W-1:0];
      default:    gain_d = floor_eff;
    endcase
  end

  // Per-channel state write-back; bypass and dropped samples leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= ST_CLOSED;
        env_q[c]  <= '0;
        gain_q[c] <= '0;
        hold_q[c] <= '0;
      end
      gate_open_q <= '0;
    end else if (wr_en) begin
      st_q[idx]        <= st_d;
      env_q[idx]       <= env_d;
      gain_q[idx]      <= gain_d;
      hold_q[idx]      <= hold_d;
      gate_open_q[idx] <= (st_d == ST_ATTACK) || (st_d == ST_OPEN) || (st_d == ST_HOLD);
    end
  end

  // Stage 1 pipeline register; bypass forces unity so the sample passes unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_data_q  <= '0;
      s1_gain_q  <= '0;
    end else begin
      s1_valid_q <= ch_ok;
      if (ch_ok) begin
        s1_ch_q   <= in_ch;
        s1_data_q <= in_data;
        s1_gain_q <= enable ? gain_d : UNITY;
      end
    end
  end

  // Signed sample times unsigned Q1 gain; the slice is the arithmetic shift
  always_comb begin
    prod_a_c      = PROD_W'($signed(s1_data_q));
    prod_b_c      = PROD_W'($signed({1'b0, s1_gain_q}));
    prod_c        = prod_a_c * prod_b_c;
    prod_unused_c = ^{prod_c[GAIN_W-2:0], prod_c[PROD_W-1:PROD_W-2]};
  end

  // Stage 2 output register; data and channel hold between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_ch_q   <= s1_ch_q;
        out_data_q <= prod_c[GAIN_W-1 +: DATA_W];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign gate_open = gate_open_q;

endmodule
